// File: rtl/ble_pkg.sv
// Shared types and constants for the BLE command receiver.
package ble_pkg;

    localparam int unsigned BAUD_DIV_DEF = 2604;   // 50 MHz / 19200 baud

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/ble_cmd_rcv_baud_tmr.sv
// Bit-timing down-counter: loads a half or full bit period, pulses expire_o
// in the last cycle of the period, then parks at zero until reloaded.
module baud_tmr #(
    parameter int unsigned BAUD_DIV = ble_pkg::BAUD_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half_i,
    input  logic load_full_i,
    output logic expire_o
);

    localparam int unsigned CW   = $clog2(BAUD_DIV) + 1;
    localparam int unsigned HALF = BAUD_DIV / 2;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire_q, expire_d;

    // expire is registered one count early so it lines up with cnt_q == 1
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (load_full_i) begin
            cnt_d    = CW'(BAUD_DIV);
            expire_d = (BAUD_DIV == 1);
        end else if (load_half_i) begin
            cnt_d    = CW'(HALF);
            expire_d = (HALF == 1);
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - CW'(1);
            expire_d = (cnt_q == CW'(2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/ble_cmd_rcv.sv
// UART command receiver (8N1) decoding 'g'/'s' into go/stop pulses.
// Define RX_PARITY_EN for 8E1 framing with a par_err output.
module ble_cmd_rcv #(
    parameter int unsigned BAUD_DIV = ble_pkg::BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       go,
    output logic       stop,
    output logic       frm_err,
    output logic       ovr_err
`ifdef RX_PARITY_EN
    ,
    output logic       par_err
`endif
);

    import ble_pkg::*;

    rx_state_e  state_q, state_d;
    logic       rx_s1_q, rx_s2_q;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rdy_q, rdy_d;
    logic       go_q, go_d;
    logic       stop_q, stop_d;
    logic       frm_err_q, frm_err_d;
    logic       ovr_err_q, ovr_err_d;
    logic       load_half, load_full, expire;
`ifdef RX_PARITY_EN
    logic       par_acc_q, par_acc_d;
    logic       par_err_q, par_err_d;
`endif

    baud_tmr #(.BAUD_DIV(BAUD_DIV)) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_half_i(load_half),
        .load_full_i(load_full),
        .expire_o   (expire)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q & ~clr_rdy;
        go_d      = 1'b0;
        stop_d    = 1'b0;
        frm_err_d = 1'b0;
        ovr_err_d = 1'b0;
        load_half = 1'b0;
        load_full = 1'b0;
`ifdef RX_PARITY_EN
        par_acc_d = par_acc_q;
        par_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s2_q) begin
                    load_half = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                // mid start bit: high again means a glitch, not a frame
                if (expire) begin
                    if (rx_s2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        load_full = 1'b1;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_DATA;
`ifdef RX_PARITY_EN
                        par_acc_d = 1'b0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    load_full = 1'b1;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef RX_PARITY_EN
                    par_acc_d = par_acc_q ^ rx_s2_q;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
`else
                    if (bit_cnt_q == 3'd7) state_d = ST_STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (expire) begin
                    load_full = 1'b1;
                    par_acc_d = par_acc_q ^ rx_s2_q;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (expire) begin
                    state_d = ST_IDLE;
                    if (!rx_s2_q) begin
                        frm_err_d = 1'b1;
`ifdef RX_PARITY_EN
                    end else if (par_acc_q) begin
                        par_err_d = 1'b1;
`endif
                    end else begin
                        // a completing byte beats a same-cycle clr_rdy
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        ovr_err_d = rdy_q & ~clr_rdy;
                        go_d      = (shift_q == CMD_GO);
                        stop_d    = (shift_q == CMD_STOP);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            go_q      <= 1'b0;
            stop_q    <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
            go_q      <= go_d;
            stop_q    <= stop_d;
            frm_err_q <= frm_err_d;
            ovr_err_q <= ovr_err_d;
`ifdef RX_PARITY_EN
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
`endif
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign go      = go_q;
    assign stop    = stop_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;
`ifdef RX_PARITY_EN
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_ble_cmd_rcv.sv
// Directed bench for ble_cmd_rcv: a fast instance (BAUD_DIV=16) for most
// scenarios and a default-rate instance for false start and latency.
module tb_ble_cmd_rcv;

    import ble_pkg::*;

    localparam int unsigned B  = 16;
    localparam int unsigned BD = BAUD_DIV_DEF;
`ifdef RX_PARITY_EN
    localparam int LAT     = 171;     // 2 + 8 + 10*16 + 1
    localparam int LAT_DEF = 27345;   // 2 + 1302 + 10*2604 + 1
`else
    localparam int LAT     = 155;     // 2 + 8 + 9*16 + 1
    localparam int LAT_DEF = 24741;   // 2 + 1302 + 9*2604 + 1
`endif

    logic       clk = 1'b0;
    logic       rst, rx, clr_rdy, rx_df;
    logic [7:0] rx_data, rx_data_df;
    logic       rdy, go, stop, frm_err, ovr_err;
    logic       rdy_df, go_df, stop_df, frm_err_df, ovr_err_df;
`ifdef RX_PARITY_EN
    logic       par_err, par_err_df;
`endif

    int vec_n = 0;
    int err_n = 0;
    int cyc   = 0;
    int fall_cyc = 0;

    ble_cmd_rcv #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(rx), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .go(go), .stop(stop),
        .frm_err(frm_err), .ovr_err(ovr_err)
`ifdef RX_PARITY_EN
        , .par_err(par_err)
`endif
    );

    ble_cmd_rcv dut_def (
        .clk(clk), .rst(rst), .RX(rx_df), .clr_rdy(1'b0),
        .rx_data(rx_data_df), .rdy(rdy_df), .go(go_df), .stop(stop_df),
        .frm_err(frm_err_df), .ovr_err(ovr_err_df)
`ifdef RX_PARITY_EN
        , .par_err(par_err_df)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse counters and rdy-rise capture, sampled mid-cycle
    int   go_n = 0, stop_n = 0, frm_n = 0, ovr_n = 0, par_n = 0, rise_cyc = 0;
    logic go_rise = 1'b0, stop_rise = 1'b0, rdy_prev = 1'b0;
    int   go_df_n = 0, stop_df_n = 0, frm_df_n = 0, rdyh_df_n = 0, rise_df_cyc = 0;
    logic rdy_df_prev = 1'b0;

    always @(negedge clk) begin
        go_n   <= go_n + int'(go);
        stop_n <= stop_n + int'(stop);
        frm_n  <= frm_n + int'(frm_err);
        ovr_n  <= ovr_n + int'(ovr_err);
`ifdef RX_PARITY_EN
        par_n  <= par_n + int'(par_err);
`endif
        if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
            rise_cyc  <= cyc;
            go_rise   <= go;
            stop_rise <= stop;
        end
        rdy_prev <= rdy;
        go_df_n   <= go_df_n + int'(go_df);
        stop_df_n <= stop_df_n + int'(stop_df);
        frm_df_n  <= frm_df_n + int'(frm_err_df);
        rdyh_df_n <= rdyh_df_n + int'(rdy_df);
        if (rdy_df === 1'b1 && rdy_df_prev !== 1'b1) rise_df_cyc <= cyc;
        rdy_df_prev <= rdy_df;
    end

    task automatic drive(input logic sel, input logic v, input int unsigned n);
        if (sel) rx_df = v; else rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] b,
                              input logic stop_bit, input logic par_flip);
        int unsigned n;
        logic        p;
        n = sel ? BD : B;
        p = (^b) ^ par_flip;
        @(posedge clk); #1;
        fall_cyc = cyc;
        drive(sel, 1'b0, n);
        for (int i = 0; i < 8; i++) drive(sel, b[i], n);
`ifdef RX_PARITY_EN
        drive(sel, p, n);
`endif
        drive(sel, stop_bit, n);
        if (sel) rx_df = 1'b1; else rx = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr_rdy = 1'b1;
        @(posedge clk); #1; clr_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_df = 1'b1; clr_rdy = 1'b0;
        repeat (3) @(posedge clk); #1;
        vec_n++; if (rx_data !== 8'h00) begin err_n++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        vec_n++; if (rdy !== 1'b0) begin err_n++; $display("FAIL reset_rdy got %b want 0", rdy); end
        vec_n++; if ({go, stop, frm_err, ovr_err} !== 4'b0) begin err_n++; $display("FAIL reset_pulses got %b want 0000", {go, stop, frm_err, ovr_err}); end
        vec_n++; if (rdy_df !== 1'b0) begin err_n++; $display("FAIL reset_rdy_df got %b want 0", rdy_df); end
`ifdef RX_PARITY_EN
        vec_n++; if (par_err !== 1'b0) begin err_n++; $display("FAIL reset_par_err got %b want 0", par_err); end
`endif
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_go();
        int g0, s0;
        g0 = go_n; s0 = stop_n;
        send_frame(1'b0, 8'h67, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        vec_n++; if (rise_cyc - fall_cyc !== LAT) begin err_n++; $display("FAIL go_latency got %0d want %0d", rise_cyc - fall_cyc, LAT); end
        vec_n++; if (rx_data !== 8'h67) begin err_n++; $display("FAIL go_rx_data got %h want 67", rx_data); end
        vec_n++; if (rdy !== 1'b1) begin err_n++; $display("FAIL go_rdy got %b want 1", rdy); end
        vec_n++; if (go_n - g0 !== 1 || go_rise !== 1'b1) begin err_n++; $display("FAIL go_pulse got cnt %0d at_rise %b want 1 1", go_n - g0, go_rise); end
        vec_n++; if (stop_n - s0 !== 0) begin err_n++; $display("FAIL go_no_stop got %0d want 0", stop_n - s0); end
        pulse_clr();
        vec_n++; if (rdy !== 1'b0) begin err_n++; $display("FAIL go_clr_rdy got %b want 0", rdy); end
    endtask

    task automatic test_stop_clr();
        int g0, s0;
        g0 = go_n; s0 = stop_n;
        send_frame(1'b0, 8'h73, 1'b1, 1'b0);
        vec_n++; if (rx_data !== 8'h73) begin err_n++; $display("FAIL stop_rx_data got %h want 73", rx_data); end
        vec_n++; if (stop_n - s0 !== 1 || stop_rise !== 1'b1) begin err_n++; $display("FAIL stop_pulse got cnt %0d at_rise %b want 1 1", stop_n - s0, stop_rise); end
        vec_n++; if (go_n - g0 !== 0) begin err_n++; $display("FAIL stop_no_go got %0d want 0", go_n - g0); end
        pulse_clr();
        vec_n++; if (rdy !== 1'b0) begin err_n++; $display("FAIL stop_clr_rdy got %b want 0", rdy); end
    endtask

    task automatic test_frame_err();
        int f0, g0, s0, o0;
        f0 = frm_n; g0 = go_n; s0 = stop_n; o0 = ovr_n;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        repeat (2 * B) @(posedge clk); #1;
        vec_n++; if (frm_n - f0 !== 1) begin err_n++; $display("FAIL frm_pulse got %0d want 1", frm_n - f0); end
        vec_n++; if (rdy !== 1'b0) begin err_n++; $display("FAIL frm_rdy got %b want 0", rdy); end
        vec_n++; if (rx_data !== 8'h73) begin err_n++; $display("FAIL frm_rx_data got %h want 73", rx_data); end
        vec_n++; if (go_n - g0 + stop_n - s0 + ovr_n - o0 !== 0) begin err_n++; $display("FAIL frm_other_pulses got %0d want 0", go_n - g0 + stop_n - s0 + ovr_n - o0); end
    endtask

    task automatic test_false_start();
        int g0, s0, f0, r0;
        g0 = go_df_n; s0 = stop_df_n; f0 = frm_df_n; r0 = rdyh_df_n;
        @(posedge clk); #1; rx_df = 1'b0;
        repeat (100) @(posedge clk); #1; rx_df = 1'b1;
        repeat (BD) @(posedge clk); #1;
        vec_n++; if (rdyh_df_n - r0 !== 0 || rdy_df !== 1'b0) begin err_n++; $display("FAIL false_rdy got %0d cycles want 0", rdyh_df_n - r0); end
        vec_n++; if (go_df_n - g0 + stop_df_n - s0 + frm_df_n - f0 !== 0) begin err_n++; $display("FAIL false_pulses got %0d want 0", go_df_n - g0 + stop_df_n - s0 + frm_df_n - f0); end
        vec_n++; if (dut_def.state_q !== ST_IDLE) begin err_n++; $display("FAIL false_state got %0d want %0d", dut_def.state_q, ST_IDLE); end
    endtask

    task automatic test_default_latency();
        int g0;
        g0 = go_df_n;
        send_frame(1'b1, 8'h67, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        vec_n++; if (rise_df_cyc - fall_cyc !== LAT_DEF) begin err_n++; $display("FAIL def_latency got %0d want %0d", rise_df_cyc - fall_cyc, LAT_DEF); end
        vec_n++; if (rx_data_df !== 8'h67) begin err_n++; $display("FAIL def_rx_data got %h want 67", rx_data_df); end
        vec_n++; if (go_df_n - g0 !== 1) begin err_n++; $display("FAIL def_go got %0d want 1", go_df_n - g0); end
    endtask

    task automatic test_back_to_back();
        int o0, g0, s0;
        o0 = ovr_n; g0 = go_n; s0 = stop_n;
        send_frame(1'b0, 8'h12, 1'b1, 1'b0);
        vec_n++; if (rx_data !== 8'h12 || rdy !== 1'b1 || ovr_n - o0 !== 0) begin err_n++; $display("FAIL b2b_first got %h rdy %b ovr %0d want 12 1 0", rx_data, rdy, ovr_n - o0); end
        send_frame(1'b0, 8'h34, 1'b1, 1'b0);
        vec_n++; if (ovr_n - o0 !== 1) begin err_n++; $display("FAIL b2b_ovr got %0d want 1", ovr_n - o0); end
        vec_n++; if (rx_data !== 8'h34 || rdy !== 1'b1) begin err_n++; $display("FAIL b2b_second got %h rdy %b want 34 1", rx_data, rdy); end
        vec_n++; if (go_n - g0 + stop_n - s0 !== 0) begin err_n++; $display("FAIL b2b_cmd got %0d want 0", go_n - g0 + stop_n - s0); end
    endtask

    task automatic test_clr_coincide();
        int o0, g0;
        o0 = ovr_n; g0 = go_n;
        fork
            send_frame(1'b0, 8'h67, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1; clr_rdy = 1'b1;
                @(posedge clk); #1; clr_rdy = 1'b0;
            end
        join
        vec_n++; if (rdy !== 1'b1) begin err_n++; $display("FAIL coinc_rdy got %b want 1", rdy); end
        vec_n++; if (ovr_n - o0 !== 0) begin err_n++; $display("FAIL coinc_ovr got %0d want 0", ovr_n - o0); end
        vec_n++; if (go_n - g0 !== 1 || rx_data !== 8'h67) begin err_n++; $display("FAIL coinc_go got %0d %h want 1 67", go_n - g0, rx_data); end
    endtask

    task automatic test_reset_mid();
        int f0, g0, s0;
        @(posedge clk); #1; rx = 1'b0;
        repeat (4 * B) @(posedge clk); #1;
        rst = 1'b1; rx = 1'b1;
        @(posedge clk); #1;
        vec_n++; if (rx_data !== 8'h00 || rdy !== 1'b0) begin err_n++; $display("FAIL rst_mid_data got %h rdy %b want 00 0", rx_data, rdy); end
        vec_n++; if ({go, stop, frm_err, ovr_err} !== 4'b0) begin err_n++; $display("FAIL rst_mid_pulses got %b want 0000", {go, stop, frm_err, ovr_err}); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        f0 = frm_n; g0 = go_n; s0 = stop_n;
        repeat (12 * B) @(posedge clk); #1;
        vec_n++; if (rdy !== 1'b0 || frm_n - f0 + go_n - g0 + stop_n - s0 !== 0) begin err_n++; $display("FAIL rst_mid_quiet got rdy %b pulses %0d want 0 0", rdy, frm_n - f0 + go_n - g0 + stop_n - s0); end
        send_frame(1'b0, 8'h73, 1'b1, 1'b0);
        vec_n++; if (rx_data !== 8'h73 || rise_cyc - fall_cyc !== LAT) begin err_n++; $display("FAIL rst_mid_resume got %h lat %0d want 73 %0d", rx_data, rise_cyc - fall_cyc, LAT); end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        int p0, g0;
        pulse_clr();
        p0 = par_n; g0 = go_n;
        send_frame(1'b0, 8'h67, 1'b1, 1'b1);
        vec_n++; if (par_n - p0 !== 1) begin err_n++; $display("FAIL par_pulse got %0d want 1", par_n - p0); end
        vec_n++; if (go_n - g0 !== 0 || rdy !== 1'b0) begin err_n++; $display("FAIL par_suppress got go %0d rdy %b want 0 0", go_n - g0, rdy); end
        vec_n++; if (rx_data !== 8'h73) begin err_n++; $display("FAIL par_rx_data got %h want 73", rx_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_go();
        test_stop_clr();
        test_frame_err();
        test_false_start();
        test_default_latency();
        test_back_to_back();
        test_clr_coincide();
        test_reset_mid();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
